// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin arbiter that drives a 2:1 data mux into a
// single-entry valid/ready output register, with saturating per-source grant counters.
module rr_mux_arbiter #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  logic             last_gnt;
  logic             grant;
  logic             any_valid;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] mux_data;

  assign any_valid = in0_valid | in1_valid;
  assign accept    = ~out_valid | out_ready;

  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = 1'b0;
    if (in0_valid && in1_valid) begin
      grant = ~last_gnt;
    end else if (in1_valid) begin
      grant = 1'b1;
    end
  end

  // Idle cycles hold the select on the last winner so the mux does not toggle.
  assign sel      = any_valid ? grant : last_gnt;
  assign mux_data = sel ? in1_data : in0_data;

  assign in0_ready = ~rst & accept & in0_valid & ~grant;
  assign in1_ready = ~rst & accept & in1_valid &  grant;
  assign xfer      = in0_ready | in1_ready;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      last_gnt  <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      last_gnt  <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Counters saturate rather than wrap so a long run still shows who dominated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (in0_ready && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (in1_ready && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed, table-driven bench for rr_mux_arbiter: a default-width instance for
// arbitration/handshake behaviour and a CNT_W=2 instance for counter saturation.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
  logic [4:0] in0_data = '0, in1_data = '0;
  logic       in0_ready, in1_ready, sel, out_valid;
  logic [4:0] out_data;
  logic [7:0] gnt_cnt0, gnt_cnt1;

  logic       s_in0_valid = 1'b0;
  logic [4:0] s_in0_data = '0;
  logic       s_in0_ready, s_in1_ready, s_sel, s_out_valid;
  logic [4:0] s_out_data;
  logic [1:0] s_cnt0, s_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  rr_mux_arbiter #(.WIDTH(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in0_valid(s_in0_valid), .in0_data(s_in0_data), .in0_ready(s_in0_ready),
    .in1_valid(1'b0), .in1_data(5'h00), .in1_ready(s_in1_ready),
    .sel(s_sel), .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(1'b1),
    .gnt_cnt0(s_cnt0), .gnt_cnt1(s_cnt1)
  );

  typedef struct {
    logic       v0;
    logic [4:0] d0;
    logic       v1;
    logic [4:0] d1;
    logic       ordy;
    logic       r0;
    logic       r1;
    logic       sel;
    logic       ov;
    logic [4:0] od;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Fields: v0 d0 v1 d1 ordy | r0 r1 sel | ov od c0 c1 (registered, after the edge)
    vecs.push_back('{1, 5'h15, 0, 5'h00, 1, 1, 0, 0, 1, 5'h15, 1, 0}); // single in0
    vecs.push_back('{1, 5'h0A, 1, 5'h15, 1, 0, 1, 1, 1, 5'h15, 1, 1}); // both: rr to in1
    vecs.push_back('{1, 5'h0A, 1, 5'h15, 1, 1, 0, 0, 1, 5'h0A, 2, 1});
    vecs.push_back('{1, 5'h0A, 1, 5'h15, 1, 0, 1, 1, 1, 5'h15, 2, 2});
    vecs.push_back('{1, 5'h0A, 1, 5'h15, 1, 1, 0, 0, 1, 5'h0A, 3, 2});
    vecs.push_back('{1, 5'h0A, 1, 5'h15, 0, 0, 0, 1, 1, 5'h0A, 3, 2}); // backpressure x3
    vecs.push_back('{1, 5'h0A, 1, 5'h15, 0, 0, 0, 1, 1, 5'h0A, 3, 2});
    vecs.push_back('{1, 5'h0A, 1, 5'h15, 0, 0, 0, 1, 1, 5'h0A, 3, 2});
    vecs.push_back('{1, 5'h0A, 1, 5'h15, 1, 0, 1, 1, 1, 5'h15, 3, 3}); // drain+load
    vecs.push_back('{0, 5'h00, 0, 5'h00, 1, 0, 0, 1, 0, 5'h15, 3, 3}); // drain only
    vecs.push_back('{0, 5'h00, 0, 5'h00, 0, 0, 0, 1, 0, 5'h15, 3, 3}); // idle, no rotate
    vecs.push_back('{0, 5'h00, 1, 5'h07, 1, 0, 1, 1, 1, 5'h07, 3, 4}); // only in1 x3
    vecs.push_back('{0, 5'h00, 1, 5'h07, 1, 0, 1, 1, 1, 5'h07, 3, 5});
    vecs.push_back('{0, 5'h00, 1, 5'h07, 1, 0, 1, 1, 1, 5'h07, 3, 6});
    vecs.push_back('{1, 5'h0A, 1, 5'h07, 1, 1, 0, 0, 1, 5'h0A, 4, 6}); // in0 next
    vecs.push_back('{1, 5'h1F, 0, 5'h00, 0, 0, 0, 0, 1, 5'h0A, 4, 6}); // full, stalled
    vecs.push_back('{0, 5'h00, 0, 5'h00, 1, 0, 0, 0, 0, 5'h0A, 4, 6}); // drain
    vecs.push_back('{1, 5'h1F, 0, 5'h00, 0, 1, 0, 0, 1, 5'h1F, 5, 6}); // empty accepts w/o ordy

    // Reset with requests present: readies must stay low.
    #1 rst = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    check("reset_in0_ready", in0_ready, 0);
    check("reset_in1_ready", in1_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_cnt0", gnt_cnt0, 0);
    check("reset_cnt1", gnt_cnt1, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      in0_valid = vecs[i].v0;
      in0_data  = vecs[i].d0;
      in1_valid = vecs[i].v1;
      in1_data  = vecs[i].d1;
      out_ready = vecs[i].ordy;
      #2;
      check($sformatf("v%0d_in0_ready", i), in0_ready, vecs[i].r0);
      check($sformatf("v%0d_in1_ready", i), in1_ready, vecs[i].r1);
      check($sformatf("v%0d_sel", i), sel, vecs[i].sel);
      step();
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].ov);
      check($sformatf("v%0d_out_data", i), out_data, vecs[i].od);
      check($sformatf("v%0d_cnt0", i), gnt_cnt0, vecs[i].c0);
      check($sformatf("v%0d_cnt1", i), gnt_cnt1, vecs[i].c1);
    end

    // Asynchronous reset mid-cycle while a word is pending.
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_cnt0", gnt_cnt0, 0);
    check("async_rst_cnt1", gnt_cnt1, 0);
    check("async_rst_in0_ready", in0_ready, 0);
    check("async_rst_in1_ready", in1_ready, 0);
    #1 rst = 1'b0;
    in0_data  = 5'h03;
    in1_data  = 5'h1C;
    out_ready = 1'b1;
    #1;
    check("post_rst_in0_ready", in0_ready, 1);
    check("post_rst_in1_ready", in1_ready, 0);
    check("post_rst_sel", sel, 0);
    step();
    check("post_rst_out_data", out_data, 5'h03);
    check("post_rst_out_valid", out_valid, 1);
    #2;
    check("post_rst_second_in1_ready", in1_ready, 1);
    step();
    check("post_rst_second_out_data", out_data, 5'h1C);
    in0_valid = 1'b0;
    in1_valid = 1'b0;

    // Saturation on the 2-bit-counter instance: 1,2,3,3,3,3.
    for (int k = 0; k < 6; k++) begin
      s_in0_valid = 1'b1;
      s_in0_data  = 5'(k + 1);
      #2;
      check($sformatf("sat%0d_in0_ready", k), s_in0_ready, 1);
      step();
      check($sformatf("sat%0d_cnt0", k), s_cnt0, (k < 3) ? k + 1 : 3);
      check($sformatf("sat%0d_out_data", k), s_out_data, k + 1);
    end
    s_in0_valid = 1'b0;
    step();
    check("sat_cnt0_hold", s_cnt0, 3);
    check("sat_cnt1", s_cnt1, 0);
    check("sat_drained", s_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
